// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Converts WIDTH-bit parallel words into a registered serial bit stream on X.
// A shift register holds the word currently on the wire. A single holding
// register takes the next word, so back-to-back words stream with no gap cycle.
//
// Parameters
//   WIDTH     : parallel word width (2..32)
//   MSB_FIRST : 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first
//   IDLE_BIT  : value on X while no word is shifting
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   data_in    in   parallel word to serialize
//   data_valid in   data_in is valid this cycle
//   data_ready out  block accepts data_in at this edge
//   X          out  registered serial bit
//   x_valid    out  X carries a data bit this cycle
//   word_done  out  last bit of a word is on X
//   bit_cnt    out  shift-order index of the bit currently on X
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     X,
  output logic                     x_valid,
  output logic                     word_done,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0]    hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                x_q, x_d;
  logic                x_valid_q, x_valid_d;
  logic                word_done_q, word_done_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                transfer;
  logic                load_en;
  logic                adv_en;
  logic [WIDTH-1:0]    load_word;

  // Bit that goes on the wire first for a given (remaining) word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Drop the bit just sent so the next one sits at the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready only when the holding slot is free; never during reset.
  assign data_ready = !hold_full_q && !reset;
  assign transfer   = data_valid && data_ready;

  // Next-state logic: decide between loading a new word, advancing, or idling.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    x_d         = IDLE_BIT;
    x_valid_d   = 1'b0;
    word_done_d = 1'b0;
    cnt_d       = '0;
    load_en     = 1'b0;
    adv_en      = 1'b0;
    load_word   = data_in;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          load_en = 1'b1;
        end else begin
          load_en = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST_IDX) begin
          adv_en = 1'b1;
          // data_ready implies the holding slot is empty here
          if (transfer) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end else begin
            hold_d = hold_q;
          end
        end else if (hold_full_q) begin
          // Word ends: the held word takes over without a gap cycle
          load_en     = 1'b1;
          load_word   = hold_q;
          hold_full_d = 1'b0;
        end else if (transfer) begin
          // Word ends with hold empty: incoming word bypasses the hold slot
          load_en = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        hold_full_d = 1'b0;
      end
    endcase

    if (load_en) begin
      state_d   = SHIFT;
      shift_d   = load_word;
      x_d       = first_bit(load_word);
      x_valid_d = 1'b1;
      cnt_d     = '0;
    end else if (adv_en) begin
      shift_d     = advance(shift_q);
      x_d         = first_bit(advance(shift_q));
      x_valid_d   = 1'b1;
      cnt_d       = cnt_q + CW'(1);
      word_done_d = ((cnt_q + CW'(1)) == LAST_IDX);
    end else begin
      x_d       = IDLE_BIT;
      x_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      word_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      word_done_q <= word_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign X         = x_q;
  assign x_valid   = x_valid_q;
  assign word_done = word_done_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Two instances: defaults (WIDTH=8, MSB first, idle 0) and WIDTH=4, LSB first,
// idle 1. Accepted words push their expected bits into a per-instance queue;
// a monitor on the falling edge pops and compares while x_valid is high and
// checks the idle values otherwise.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] din_a;
  logic       dv_a, rdy_a, x_a, xv_a, wd_a;
  logic [2:0] cnt_a;
  logic [3:0] din_b;
  logic       dv_b, rdy_b, x_b, xv_b, wd_b;
  logic [1:0] cnt_b;

  bit_serializer u_a (
    .clk(clk), .reset(reset), .data_in(din_a), .data_valid(dv_a),
    .data_ready(rdy_a), .X(x_a), .x_valid(xv_a), .word_done(wd_a),
    .bit_cnt(cnt_a)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_b (
    .clk(clk), .reset(reset), .data_in(din_b), .data_valid(dv_b),
    .data_ready(rdy_b), .X(x_b), .x_valid(xv_b), .word_done(wd_b),
    .bit_cnt(cnt_b)
  );

  typedef struct {
    logic x;
    int   cnt;
    logic done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  int   waits;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Expected serial stream of an accepted word.
  function automatic void push_word(int d, logic [31:0] w);
    exp_t e;
    if (d == 0) begin
      for (int i = 0; i < 8; i++) begin
        e.x = w[7-i]; e.cnt = i; e.done = (i == 7);
        q_a.push_back(e);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        e.x = w[i]; e.cnt = i; e.done = (i == 3);
        q_b.push_back(e);
      end
    end
  endfunction

  // Monitor for instance A
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_x_valid", {31'd0, xv_a}, {31'd0, q_a.size() != 0});
      if (xv_a && q_a.size() != 0) begin
        ea = q_a.pop_front();
        chk("a_X", {31'd0, x_a}, {31'd0, ea.x});
        chk("a_bit_cnt", {29'd0, cnt_a}, ea.cnt);
        chk("a_word_done", {31'd0, wd_a}, {31'd0, ea.done});
      end else if (!xv_a) begin
        chk("a_idle_X", {31'd0, x_a}, 32'd0);
        chk("a_idle_done", {31'd0, wd_a}, 32'd0);
        chk("a_idle_cnt", {29'd0, cnt_a}, 32'd0);
      end
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    if (mon_en) begin
      chk("b_x_valid", {31'd0, xv_b}, {31'd0, q_b.size() != 0});
      if (xv_b && q_b.size() != 0) begin
        eb = q_b.pop_front();
        chk("b_X", {31'd0, x_b}, {31'd0, eb.x});
        chk("b_bit_cnt", {30'd0, cnt_b}, eb.cnt);
        chk("b_word_done", {31'd0, wd_b}, {31'd0, eb.done});
      end else if (!xv_b) begin
        chk("b_idle_X", {31'd0, x_b}, 32'd1);
        chk("b_idle_done", {31'd0, wd_b}, 32'd0);
        chk("b_idle_cnt", {30'd0, cnt_b}, 32'd0);
      end
    end
  end

  // Offer a word (holding data_valid) until accepted; report stalled cycles.
  task automatic send(input int d, input logic [31:0] w, output int nwait);
    bit done_s;
    done_s = 1'b0;
    nwait  = 0;
    for (int t = 0; t < 50 && !done_s; t++) begin
      @(negedge clk);
      if (d == 0) begin din_a = w[7:0]; dv_a = 1'b1; end
      else begin din_b = w[3:0]; dv_b = 1'b1; end
      #1;
      if ((d == 0) ? rdy_a : rdy_b) begin
        @(posedge clk);
        push_word(d, w);
        done_s = 1'b1;
      end else begin
        @(posedge clk);
        nwait++;
      end
    end
    if (!done_s) begin
      checks++; failures++;
      $display("FAIL send_timeout: word %0h not accepted within 50 cycles", w);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dv_a = 1'b0; dv_b = 1'b0;
      @(posedge clk);
    end
  endtask

  // Stop offering data and wait until all expected bits were observed.
  task automatic drain();
    int t;
    @(negedge clk);
    dv_a = 1'b0; dv_b = 1'b0;
    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d/%0d bits left, required 0", q_a.size(), q_b.size());
    end
    idle(3);
  endtask

  // Reset for n edges while offering a word that must be ignored.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; dv_a = 1'b1; din_a = 8'hAA; dv_b = 1'b1; din_b = 4'h5;
    #1;
    chk("ready_a_in_reset", {31'd0, rdy_a}, 32'd0);
    chk("ready_b_in_reset", {31'd0, rdy_b}, 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      q_a.delete(); q_b.delete();
      mon_en = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("reset_ready_a", {31'd0, rdy_a}, 32'd0);
    chk("reset_xv_a", {31'd0, xv_a}, 32'd0);
    chk("reset_X_a", {31'd0, x_a}, 32'd0);
    chk("reset_X_b", {31'd0, x_b}, 32'd1);
    reset = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
    #1;
    chk("ready_a_after_reset", {31'd0, rdy_a}, 32'd1);
    chk("ready_b_after_reset", {31'd0, rdy_b}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    din_a = 8'h00; dv_a = 1'b0;
    din_b = 4'h0;  dv_b = 1'b0;

    do_reset(2);
    idle(2);

    // Single word: 8'hB4 -> 1,0,1,1,0,1,0,0
    send(0, 32'hB4, waits);
    idle(12);

    // Back-to-back FF then 00, no gap
    send(0, 32'hFF, waits);
    send(0, 32'h00, waits);
    chk("b2b_second_wait", waits, 32'd0);
    drain();

    // Backpressure: third word stalls until the first word ends
    send(0, 32'hA5, waits);
    send(0, 32'h3C, waits);
    chk("bp_second_wait", waits, 32'd0);
    send(0, 32'h81, waits);
    chk("bp_third_wait", waits, 32'd7);
    drain();

    // Reset mid-word: F0 shifting, 0F held, reset after 3 bits
    send(0, 32'hF0, waits);
    send(0, 32'h0F, waits);
    idle(1);
    do_reset(1);
    idle(12);

    // Narrow LSB-first instance with idle level 1
    send(1, 32'h1, waits);
    drain();
    send(1, 32'hA, waits);
    send(1, 32'h6, waits);
    chk("b_b2b_wait", waits, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 shifts bit WIDTH-1 first and 0 shifts bit 0 first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, giving the value driven on X when no word is shifting.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port data_in, input, WIDTH bits: the parallel word to serialize.
REQ-007 The block SHALL have port data_valid, input, 1 bit: data_in is valid this cycle.
REQ-008 The block SHALL have port data_ready, output, 1 bit: the block accepts data_in at this edge.
REQ-009 The block SHALL have port X, output, 1 bit: registered serial bit stream to the downstream sequence detector.
REQ-010 The block SHALL have port x_valid, output, 1 bit: X carries a data bit this cycle.
REQ-011 The block SHALL have port word_done, output, 1 bit: high while the last bit of a word is on X.
REQ-012 The block SHALL have port bit_cnt, output, clog2(WIDTH) bits: index (0-based, in shift order) of the bit currently on X.

Function
REQ-013 A transfer SHALL occur at a rising edge where data_valid=1 and data_ready=1; otherwise data_in is ignored.
REQ-014 Storage SHALL be one shift register plus one holding register (hold_full flag), with data_ready = !hold_full and reset inactive.
REQ-015 FSM states SHALL be IDLE (x_valid=0) and SHIFT (x_valid=1).
REQ-016 IDLE with a transfer: the word SHALL load into the shift register, the state SHALL go to SHIFT, and the first bit SHALL appear on X in the cycle after the accepting edge (latency 1).
REQ-017 In SHIFT, each edge SHALL advance X to the next bit in shift order and increment bit_cnt; each word SHALL occupy exactly WIDTH consecutive x_valid cycles.
REQ-018 A transfer in SHIFT while hold is empty SHALL write the holding register and set hold_full.
REQ-019 Edge ending a word (bit_cnt=WIDTH-1) with hold_full=1: the held word SHALL move to the shift register, hold_full SHALL clear, and the state SHALL stay SHIFT with no gap cycle.
REQ-020 Edge ending a word with hold empty and a simultaneous transfer: the incoming word SHALL bypass hold into the shift register, with no gap cycle.
REQ-021 Edge ending a word with hold empty and no transfer: the state SHALL go to IDLE, with X=IDLE_BIT, x_valid=0, and bit_cnt=0.
REQ-022 word_done SHALL be high exactly when x_valid=1 and bit_cnt=WIDTH-1, giving one cycle per word.
REQ-023 A word SHALL never be dropped, duplicated or reordered; with data_valid held high, throughput SHALL be one bit per cycle indefinitely.
REQ-024 data_in changes while data_ready=0 SHALL have no effect.

Reset
REQ-025 At an edge with reset=1, the block SHALL set state=IDLE, X=IDLE_BIT, x_valid=0, word_done=0, bit_cnt=0, and hold_full=0; data_ready SHALL be 0 while reset is asserted.
REQ-026 Reset mid-word SHALL discard both the shifting and the held word, with no partial bits after the reset edge.
REQ-027 A transfer presented in the same cycle as reset SHALL be ignored; data_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-028 Single word, defaults: accept 8'hB4 at edge n -> X = 1,0,1,1,0,1,0,0 in cycles n+1..n+8; x_valid high for exactly those cycles; word_done only in n+8; then X=0, x_valid=0.
REQ-029 Back-to-back: data_valid held with 8'hFF then 8'h00 -> 16 contiguous x_valid cycles (eight 1s then eight 0s); word_done in cycles 8 and 16 only.
REQ-030 Backpressure: present 8'hA5, 8'h3C, 8'h81 continuously -> data_ready low from after the 2nd accept until the edge ending word 1; the output stream is A5, 3C, 81 in order with no gaps.
REQ-031 Reset mid-word: accept 8'hF0, queue 8'h0F, assert reset after 3 bits -> next cycle x_valid=0, X=0, data_ready=0; after deassert, no bits of either word appear.
REQ-032 MSB_FIRST=0, IDLE_BIT=1, WIDTH=4: accept 4'h1 -> X = 1,0,0,0 with bit_cnt 0..3; idle before and after with X=1 and x_valid=0.
